// File: rtl/bill_acceptor_pkg.sv
// rtl/bill_acceptor_pkg.sv - one-hot state encodings and bill code constants
package bill_acceptor_pkg;

  typedef enum logic [6:0] {
    S_IDLE     = 7'b0000001,
    S_VALIDATE = 7'b0000010,
    S_ACCEPT   = 7'b0000100,
    S_STACK    = 7'b0001000,
    S_REJECT   = 7'b0010000,
    S_WAIT_CLR = 7'b0100000,
    S_JAM      = 7'b1000000
  } state_t;

  localparam logic [1:0] CODE_TEN    = 2'b01;
  localparam logic [1:0] CODE_TWENTY = 2'b10;

  function automatic logic code_is_valid(input logic [1:0] code);
    return (code == CODE_TEN) || (code == CODE_TWENTY);
  endfunction

endpackage

// File: rtl/bill_sample_debounce.sv
// rtl/bill_sample_debounce.sv - latches the first code sample and counts identical follow-ups
module bill_sample_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [1:0] i_code,
  output logic [1:0] o_code,
  output logic       o_mismatch,
  output logic       o_reached,
  output logic       o_stable_valid
);
  import bill_acceptor_pkg::*;

  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Load counts the first sample as 1; each matching sample afterwards steps the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code <= 2'b00;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_code <= i_code;
      r_cnt  <= CNT_W'(1);
    end else if (i_step) begin
      r_cnt  <= w_cnt_inc;
    end
  end

  assign w_cnt_inc      = r_cnt + CNT_W'(1);
  assign o_code         = r_code;
  assign o_mismatch     = (i_code != r_code);
  // The sample being taken now is the one that brings the count up to DEBOUNCE
  assign o_reached      = (w_cnt_inc == CNT_W'(DEBOUNCE));
  assign o_stable_valid = o_reached & code_is_valid(r_code);

endmodule

// File: rtl/bill_acceptor.sv
// rtl/bill_acceptor.sv - bill validator controller emitting Ten/Twenty pulses; option BILL_ACCEPTOR_COUNT_EN
module bill_acceptor #(
  parameter int DEBOUNCE      = 4,
  parameter int REJ_CYCLES    = 8,
  parameter int STACK_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic        BillIn,
  input  logic [1:0]  BillCode,
  input  logic        Ready,
  input  logic        Bill,
  input  logic        Dispense,
  input  logic        Return,
  input  logic        StackDone,
  output logic        Ten,
  output logic        Twenty,
  output logic        Stack,
  output logic        Reject,
  output logic        Busy,
  output logic        Jam
`ifdef BILL_ACCEPTOR_COUNT_EN
  ,
  output logic [15:0] TensTotal,
  output logic [15:0] TwentiesTotal
`endif
);
  import bill_acceptor_pkg::*;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accepting;
  logic             w_load;
  logic             w_step;
  logic [1:0]       w_code;
  logic             w_mismatch;
  logic             w_reached;
  logic             w_stable_valid;
  logic             r_ten;
  logic             r_twenty;
  logic             r_stack;
  logic             r_reject;
  logic             r_busy;
  logic             r_jam;

  assign w_accepting = (Ready | Bill) & ~Dispense & ~Return;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  bill_sample_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_debounce (
    .i_clk          (Clock),
    .i_rst_n        (Clear_n),
    .i_load         (w_load),
    .i_step         (w_step),
    .i_code         (BillCode),
    .o_code         (w_code),
    .o_mismatch     (w_mismatch),
    .o_reached      (w_reached),
    .o_stable_valid (w_stable_valid)
  );

  // Next-state and shared timer update; r_cnt times REJECT hold and STACK timeout
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (BillIn && w_accepting) begin
          w_next_state = S_VALIDATE;
          w_load       = 1'b1;
        end else if (BillIn) begin
          w_next_state = S_REJECT;
          w_cnt_next   = '0;
        end
      end
      S_VALIDATE: begin
        if (!BillIn) begin
          w_next_state = S_IDLE;
        end else if (!w_accepting || w_mismatch) begin
          w_next_state = S_REJECT;
          w_cnt_next   = '0;
        end else begin
          w_step = 1'b1;
          if (w_reached) begin
            w_next_state = w_stable_valid ? S_ACCEPT : S_REJECT;
            w_cnt_next   = '0;
          end
        end
      end
      S_ACCEPT: begin
        w_next_state = S_STACK;
        w_cnt_next   = '0;
      end
      S_STACK: begin
        // StackDone beats a timeout landing on the same edge
        if (StackDone) begin
          w_next_state = S_WAIT_CLR;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(STACK_TIMEOUT)) begin
            w_next_state = S_JAM;
          end
        end
      end
      S_REJECT: begin
        if (w_cnt_inc == CNT_W'(REJ_CYCLES)) begin
          w_next_state = S_WAIT_CLR;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_WAIT_CLR: begin
        if (!BillIn) begin
          w_next_state = S_IDLE;
        end
      end
      S_JAM: begin
        w_next_state = S_JAM;
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, timer and registered Moore outputs decoded from the state being entered
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ten    <= 1'b0;
      r_twenty <= 1'b0;
      r_stack  <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
      r_jam    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_ten    <= (w_next_state == S_ACCEPT) && (w_code == CODE_TEN);
      r_twenty <= (w_next_state == S_ACCEPT) && (w_code == CODE_TWENTY);
      r_stack  <= (w_next_state == S_STACK);
      r_reject <= (w_next_state == S_REJECT);
      r_busy   <= (w_next_state != S_IDLE);
      r_jam    <= (w_next_state == S_JAM);
    end
  end

  assign Ten    = r_ten;
  assign Twenty = r_twenty;
  assign Stack  = r_stack;
  assign Reject = r_reject;
  assign Busy   = r_busy;
  assign Jam    = r_jam;

`ifdef BILL_ACCEPTOR_COUNT_EN
  logic [15:0] r_tens_total;
  logic [15:0] r_twenties_total;

  // Saturating totals that step together with the pulse they count
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_tens_total     <= '0;
      r_twenties_total <= '0;
    end else if (w_next_state == S_ACCEPT) begin
      if (w_code == CODE_TEN && r_tens_total != 16'hFFFF) begin
        r_tens_total <= r_tens_total + 16'd1;
      end
      if (w_code == CODE_TWENTY && r_twenties_total != 16'hFFFF) begin
        r_twenties_total <= r_twenties_total + 16'd1;
      end
    end
  end

  assign TensTotal     = r_tens_total;
  assign TwentiesTotal = r_twenties_total;
`endif

endmodule

// File: tb/tb_bill_acceptor.sv
// tb/tb_bill_acceptor.sv - vector table, corner sequences and random episodes against an outcome model
module tb_bill_acceptor;
  localparam int DEBOUNCE   = 4;
  localparam int REJ_CYCLES = 8;
  localparam int N          = 40;

  logic       Clock = 1'b0;
  logic       Clear_n = 1'b1;
  logic       BillIn = 1'b0;
  logic [1:0] BillCode = 2'b00;
  logic       Ready = 1'b0, Bill = 1'b0, Dispense = 1'b0, Return = 1'b0, StackDone = 1'b0;
  logic       Ten, Twenty, Stack, Reject, Busy, Jam;
`ifdef BILL_ACCEPTOR_COUNT_EN
  logic [15:0] TensTotal, TwentiesTotal;
`endif

  int checks = 0;
  int errors = 0;
  int ex_tens = 0;
  int ex_twenties = 0;

  always #5 Clock = ~Clock;

  bill_acceptor dut (
    .Clock(Clock), .Clear_n(Clear_n), .BillIn(BillIn), .BillCode(BillCode),
    .Ready(Ready), .Bill(Bill), .Dispense(Dispense), .Return(Return),
    .StackDone(StackDone), .Ten(Ten), .Twenty(Twenty), .Stack(Stack),
    .Reject(Reject), .Busy(Busy), .Jam(Jam)
`ifdef BILL_ACCEPTOR_COUNT_EN
    , .TensTotal(TensTotal), .TwentiesTotal(TwentiesTotal)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {Ten, Twenty, Stack, Reject, Busy, Jam};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       bi;
    logic [1:0] code;
    logic       rdy, bl, dsp, sd;
    logic [5:0] exp;   // {Ten, Twenty, Stack, Reject, Busy, Jam}
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic bi, input logic [1:0] code, input logic rdy, input logic bl,
                     input logic dsp, input logic sd, input logic [5:0] exp);
    vec_t v;
    v.bi = bi; v.code = code; v.rdy = rdy; v.bl = bl; v.dsp = dsp; v.sd = sd; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------- episode model ----------------
  logic       e_bi[N], e_rdy[N], e_bl[N], e_dsp[N], e_ret[N], e_sd[N];
  logic [1:0] e_code[N];
  logic       o_ten[N], o_tw[N], o_stk[N], o_rej[N], o_busy[N], o_jam[N];

  function automatic bit acc_at(input int t);
    return (e_rdy[t] | e_bl[t]) & ~e_dsp[t] & ~e_ret[t];
  endfunction

  task automatic fill(input int h, input logic [1:0] c, input int sds);
    for (int j = 0; j < N; j++) begin
      e_bi[j] = (j < h); e_code[j] = c; e_rdy[j] = 1'b1; e_bl[j] = 1'b0;
      e_dsp[j] = 1'b0; e_ret[j] = 1'b0; e_sd[j] = (j >= sds);
    end
  endtask

  task automatic run_episode(input string tag);
    int kind, ridx, pidx, s, n_ten, n_tw, n_rej, n_stk, n_jam, f_pulse, f_rej;
    logic [1:0] c0;
    for (int j = 0; j < N; j++) begin
      BillIn = e_bi[j]; BillCode = e_code[j]; Ready = e_rdy[j]; Bill = e_bl[j];
      Dispense = e_dsp[j]; Return = e_ret[j]; StackDone = e_sd[j];
      @(posedge Clock); #1;
      o_ten[j] = Ten; o_tw[j] = Twenty; o_stk[j] = Stack; o_rej[j] = Reject;
      o_busy[j] = Busy; o_jam[j] = Jam;
    end
    BillIn = 1'b0; StackDone = 1'b0;
    // outcome: 0 nothing, 1 rejected starting at output ridx, 2 pulse at output pidx
    c0 = e_code[0]; ridx = 0; pidx = 0;
    if (!acc_at(0)) kind = 1;
    else begin
      kind = 2;
      for (int t = 1; t < DEBOUNCE && kind == 2; t++) begin
        if (!e_bi[t]) kind = 0;
        else if (!acc_at(t) || e_code[t] != c0) begin kind = 1; ridx = t; end
      end
      if (kind == 2) begin
        if (c0 == 2'b01 || c0 == 2'b10) pidx = DEBOUNCE - 1;
        else begin kind = 1; ridx = DEBOUNCE - 1; end
      end
    end
    n_ten = 0; n_tw = 0; n_rej = 0; n_stk = 0; n_jam = 0; f_pulse = -1; f_rej = -1;
    for (int j = 0; j < N; j++) begin
      n_ten += int'(o_ten[j]); n_tw += int'(o_tw[j]); n_rej += int'(o_rej[j]);
      n_stk += int'(o_stk[j]); n_jam += int'(o_jam[j]);
      if ((o_ten[j] || o_tw[j]) && f_pulse < 0) f_pulse = j;
      if (o_rej[j] && f_rej < 0) f_rej = j;
    end
    check({tag, "_ten_cnt"}, n_ten, (kind == 2 && c0 == 2'b01) ? 1 : 0);
    check({tag, "_twenty_cnt"}, n_tw, (kind == 2 && c0 == 2'b10) ? 1 : 0);
    check({tag, "_reject_cycles"}, n_rej, (kind == 1) ? REJ_CYCLES : 0);
    check({tag, "_jam"}, n_jam, 0);
    check({tag, "_end_busy"}, o_busy[N-1], 1'b0);
    if (kind == 2) begin
      s = pidx + 2;
      while (s < N - 1 && !e_sd[s]) s++;
      check({tag, "_pulse_at"}, f_pulse, pidx);
      check({tag, "_stack_cycles"}, n_stk, s - (pidx + 1));
      if (c0 == 2'b01) ex_tens++; else ex_twenties++;
    end else begin
      check({tag, "_stack_cycles"}, n_stk, 0);
    end
    if (kind == 1) check({tag, "_reject_at"}, f_rej, ridx);
  endtask

  initial begin
    int n, r, h, sds;
    logic [1:0] base;
    logic ok;

    // asynchronous reset without any clock edge
    #1 Clear_n = 1'b0;
    #1 check("reset_outputs", outs(), 6'b000000);
    @(negedge Clock); Clear_n = 1'b1;

    // $10 with Ready, StackDone after 5 STACK cycles
    for (int i = 0; i < 3; i++) add(1, 2'b01, 1, 0, 0, 0, 6'b000010);
    add(1, 2'b01, 1, 0, 0, 0, 6'b100010);
    for (int i = 0; i < 5; i++) add(1, 2'b01, 1, 0, 0, 0, 6'b001010);
    add(1, 2'b01, 1, 0, 0, 1, 6'b000010);
    add(0, 2'b01, 1, 0, 0, 0, 6'b000000);
    add(0, 2'b01, 1, 0, 0, 0, 6'b000000);
    // Dispense high as bill arrives: straight to an 8-cycle reject
    add(1, 2'b01, 1, 0, 1, 0, 6'b000110);
    for (int i = 0; i < 7; i++) add(1, 2'b01, 1, 0, 0, 0, 6'b000110);
    add(1, 2'b01, 1, 0, 0, 0, 6'b000010);
    add(0, 2'b01, 1, 0, 0, 0, 6'b000000);
    // $20 accepted on Bill status, StackDone on first STACK edge
    for (int i = 0; i < 3; i++) add(1, 2'b10, 0, 1, 0, 0, 6'b000010);
    add(1, 2'b10, 0, 1, 0, 1, 6'b010010);
    add(1, 2'b10, 0, 1, 0, 1, 6'b001010);
    add(0, 2'b10, 0, 1, 0, 1, 6'b000010);
    add(0, 2'b10, 0, 1, 0, 0, 6'b000000);
    for (int i = 0; i < vecs.size(); i++) begin
      BillIn = vecs[i].bi; BillCode = vecs[i].code; Ready = vecs[i].rdy; Bill = vecs[i].bl;
      Dispense = vecs[i].dsp; Return = 1'b0; StackDone = vecs[i].sd;
      @(posedge Clock); #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // corner sequences through the outcome model
    fill(15, 2'b11, 10); run_episode("invalid_code");
    fill(10, 2'b01, 10); e_code[0] = 2'b10; run_episode("code_change");
    fill(1, 2'b10, 10); run_episode("early_drop");
    fill(12, 2'b10, 10); e_ret[2] = 1'b1; run_episode("return_mid_validate");
    fill(12, 2'b01, 10); e_dsp[0] = 1'b1; run_episode("dispense_at_entry");

    // stacker never acknowledges: jam after 255 STACK cycles, sticky until Clear_n
    BillIn = 1'b1; BillCode = 2'b10; Ready = 1'b1; Bill = 1'b0; Dispense = 1'b0;
    Return = 1'b0; StackDone = 1'b0;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge Clock); #1; if (Stack) ok = 1'b1; end
    check("jam_stack_seen", ok, 1'b1);
    n = 1; ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge Clock); #1;
      if (Jam) ok = 1'b1; else if (Stack) n++;
    end
    check("jam_seen", ok, 1'b1);
    check("jam_stack_cycles", n, 255);
    check("jam_outputs", outs(), 6'b000011);
    BillIn = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge Clock); #1; end
    check("jam_sticky", outs(), 6'b000011);
    #2 Clear_n = 1'b0;
    #1 check("jam_async_clear", outs(), 6'b000000);
    @(negedge Clock); Clear_n = 1'b1;

    // reset mid-validation aborts the bill with no pulse
    BillIn = 1'b1; BillCode = 2'b01;
    @(posedge Clock); @(posedge Clock); #1;
    check("midreset_busy_before", Busy, 1'b1);
    Clear_n = 1'b0; BillIn = 1'b0;
    #1 check("midreset_async", outs(), 6'b000000);
    @(negedge Clock); Clear_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(posedge Clock); #1; n += int'(Ten) + int'(Twenty) + int'(Busy); end
    check("midreset_quiet", n, 0);

    // random episodes
    ex_tens = 0; ex_twenties = 0;
    for (int e = 0; e < 60; e++) begin
      h = $urandom_range(1, 30);
      sds = $urandom_range(0, 20);
      r = $urandom_range(0, 5);
      base = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r == 4) ? 2'b00 : 2'b11;
      for (int j = 0; j < N; j++) begin
        e_bi[j]   = (j < h);
        e_code[j] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : base;
        e_rdy[j]  = ($urandom_range(0, 7) != 0);
        e_bl[j]   = 1'($urandom_range(0, 1));
        e_dsp[j]  = ($urandom_range(0, 23) == 0);
        e_ret[j]  = ($urandom_range(0, 23) == 0);
        e_sd[j]   = (j >= sds);
      end
      run_episode($sformatf("rnd%0d", e));
    end
`ifdef BILL_ACCEPTOR_COUNT_EN
    check("tens_total", TensTotal, ex_tens);
    check("twenties_total", TwentiesTotal, ex_twenties);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bill_acceptor.md
Name: bill_acceptor

Overview:
Front-end bill validator controller. It is the transmitter side of the Ten/Twenty pulse interface that the ticket vending FSM consumes.
- Qualifies raw validator codes, holds the bill in escrow, then emits exactly one single-cycle Ten or Twenty pulse per accepted bill.
- Drives the stacker and reject mechanisms.
- Gates acceptance on the vending FSM status outputs (Ready, Bill, Dispense, Return).

Parameters:
DEBOUNCE, 4, consecutive identical samples required before accepting (>=2)
REJ_CYCLES, 8, cycles Reject is held high
STACK_TIMEOUT, 255, max cycles waiting for StackDone before declaring a jam
CNT_W, 8, width of internal cycle counter (must hold max(DEBOUNCE, REJ_CYCLES, STACK_TIMEOUT))

Ports:
Clock  in  1  system clock, posedge
Clear_n  in  1  asynchronous active-low reset
BillIn  in  1  validator: bill present in throat
BillCode  in  2  validator denomination: 01=$10, 10=$20, 00/11=invalid
Ready  in  1  vending FSM Ready status
Bill  in  1  vending FSM Bill (partial-credit) status
Dispense  in  1  vending FSM Dispense status
Return  in  1  vending FSM Return status
StackDone  in  1  stacker mechanism ack, level
Ten  out  1  one-cycle pulse: $10 accepted
Twenty  out  1  one-cycle pulse: $20 accepted
Stack  out  1  command stacker to take escrowed bill
Reject  out  1  command bill ejection
Busy  out  1  high in every state except IDLE
Jam  out  1  sticky stacker fault

Behaviour:
- Reset: one cycle clock and one asynchronous active-low reset (Clock, Clear_n). Clear_n low forces, immediately and asynchronously:
  - State=IDLE, counter=0.
  - All outputs 0, including Jam.
- Reset mid-operation aborts any transaction with no pulse emitted.
- All outputs are registered and decoded from state only (Moore). Ten, Twenty and Reject never glitch.
- Accepting = (Ready | Bill) & ~Dispense & ~Return.
- States are one-hot: IDLE, VALIDATE, ACCEPT, STACK, REJECT, WAIT_CLR, JAM.
- IDLE:
  - BillIn & Accepting -> VALIDATE; latch BillCode; cnt=1 (this sample counts as the first).
  - BillIn & ~Accepting -> REJECT.
- VALIDATE, per edge, in this priority:
  - BillIn low -> IDLE, no output.
  - ~Accepting or BillCode != latched code -> REJECT.
  - Otherwise cnt++. When cnt reaches DEBOUNCE: latched code valid -> ACCEPT; invalid -> REJECT.
- ACCEPT:
  - Exactly one cycle; Ten (code 01) or Twenty (code 10) high.
  - Unconditionally -> STACK, cnt=0.
- STACK:
  - Stack high.
  - StackDone -> WAIT_CLR.
  - Else cnt++; cnt==STACK_TIMEOUT -> JAM.
  - StackDone and timeout on the same edge: StackDone wins.
- REJECT:
  - Reject high for exactly REJ_CYCLES cycles, then -> WAIT_CLR.
  - No Ten/Twenty is ever emitted for a rejected bill.
- WAIT_CLR: stay while BillIn high; BillIn low -> IDLE. This guarantees one bill equals at most one pulse.
- JAM:
  - Jam high; Stack, Reject, Ten, Twenty low.
  - Busy high; exits only on reset.
- Latency: with code stable and sampled first at edge k, Ten/Twenty is high during the cycle following edge k+DEBOUNCE-1.
- Ten and Twenty are mutually exclusive and never high on consecutive cycles.
- Dispense or Return asserting while in STACK does not abort stacking; the credit has already been sent.

Optional Feature:
Macro BILL_ACCEPTOR_COUNT_EN.
- Defined: adds outputs TensTotal[15:0] and TwentiesTotal[15:0].
  - Each increments on the cycle its pulse is emitted.
  - Saturates at 16'hFFFF; cleared only by Clear_n.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bill_acceptor_pkg holds:
  - One-hot state encodings (7 bits).
  - BillCode constants CODE_TEN=2'b01, CODE_TWENTY=2'b10.
- One sub-module, bill_sample_debounce, is natural: code latch, compare and DEBOUNCE counter, with outputs stable_valid / mismatch.
- The FSM and timers stay in bill_acceptor.

Test Plan:
- Ready=1, BillIn=1, BillCode=01 held from edge 0: Ten=1 only in the cycle after edge 3, Stack rises next cycle. StackDone after 5 cycles, then BillIn=0 -> IDLE, Busy=0.
- BillCode=11 held 4 samples: Reject=1 for 8 cycles, Ten=Twenty=0 throughout. BillIn released -> IDLE.
- BillCode 10 changes to 01 at the second sample: REJECT entered, no pulse. BillIn dropped after 1 sample instead: back to IDLE with no Reject.
- Dispense=1 when BillIn rises -> immediate REJECT. Return asserted mid-VALIDATE -> REJECT, no pulse.
- StackDone never asserted: Jam=1 after 255 STACK cycles, stays high; Clear_n pulse clears Jam and all outputs asynchronously.
- BILL_ACCEPTOR_COUNT_EN: 3 tens and 2 twenties accepted -> TensTotal=3, TwentiesTotal=2. Preloading to saturation by forcing confirms TensTotal holds at 16'hFFFF.
